mr_wb_arb: RTL and testbench



---
 rtl/mr_wb_pkg.sv | 28 ++
 rtl/mr_wb_txn_ctr.sv | 38 +++
 rtl/mr_wb_arb.sv | 155 +++++++++++++++
 tb/tb_mr_wb_arb.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mr_wb_pkg.sv
// Shared types and bus widths for the two-master Wishbone arbiter.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef XLEN_GRAN
`define XLEN_GRAN 2
`endif

package mr_wb_pkg;

  localparam int WB_DW   = `XLEN;
  localparam int WB_AW   = `XLEN - `XLEN_GRAN;
  localparam int WB_SELW = WB_DW / 8;

  // IDLE  : no owner, slave cycle low, waiting for a request
  // OWN0  : ifetch owns the slave port (pass-through)
  // OWN1  : load-store owns the slave port (pass-through)
  // DRAIN : owner preempted, no new strobes, collecting outstanding acks
  // GAP   : one idle cycle on the slave before handing over to the other master
  typedef enum logic [2:0] {
    IDLE,
    OWN0,
    OWN1,
    DRAIN,
    GAP
  } arb_state_e;

endpackage

// File: rtl/mr_wb_txn_ctr.sv
// Outstanding-strobe counter: counts accepted strobes up, completions down,
// never wraps in either direction, and can be cleared when a tenure ends.
module mr_wb_txn_ctr #(
  parameter int MAX_OUTST = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr,
  input  logic                           inc,
  input  logic                           dec,
  output logic [$clog2(MAX_OUTST+1)-1:0] count,
  output logic                           full,
  output logic                           zero
);

  localparam int CW = $clog2(MAX_OUTST + 1);

  logic up;
  logic dn;

  assign full = (count == CW'(MAX_OUTST));
  assign zero = (count == '0);
  // a completion with nothing outstanding is stray and must not underflow
  assign up   = inc & ~full;
  assign dn   = dec & ~zero;

  // count update; simultaneous accept and completion cancel out
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (up && !dn) begin
      count <= count + CW'(1);
    end else if (dn && !up) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/mr_wb_arb.sv
// Two-master to one-slave pipelined Wishbone arbiter with round-robin ties,
// outstanding-strobe limiting and starvation preemption of the current owner.
module mr_wb_arb
  import mr_wb_pkg::*;
#(
  parameter int AW           = WB_AW,
  parameter int DW           = WB_DW,
  parameter int MAX_OUTST    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic            m0_stall_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            m1_stall_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  input  logic            s_stall_i
);

  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_e    state;
  logic          owner;
  logic          last_owner;
  logic [SW-1:0] starve;

  logic          own_cyc;
  logic          own_stb;
  logic          other_cyc;
  logic          passing;
  logic          draining;
  logic          accept;
  logic          done;
  logic          release_bus;
  logic          ctr_clr;
  logic          full;
  logic          zero;
  logic          drain_done;
  logic          starve_hit;
  logic          pick;
  logic [CW-1:0] outst;

  assign own_cyc   = owner ? m1_cyc_i : m0_cyc_i;
  assign own_stb   = owner ? m1_stb_i : m0_stb_i;
  assign other_cyc = owner ? m0_cyc_i : m1_cyc_i;

  assign passing   = (state == OWN0) || (state == OWN1);
  assign draining  = (state == DRAIN);

  assign s_cyc_o   = (passing & own_cyc) | draining;
  assign s_stb_o   = passing & own_stb & ~full;
  assign s_we_o    = owner ? m1_we_i  : m0_we_i;
  assign s_adr_o   = owner ? m1_adr_i : m0_adr_i;
  assign s_dat_o   = owner ? m1_dat_i : m0_dat_i;
  assign s_sel_o   = owner ? m1_sel_i : m0_sel_i;

  assign m0_stall_o = ~(passing & ~owner) | s_stall_i | full;
  assign m1_stall_o = ~(passing &  owner) | s_stall_i | full;
  assign m0_ack_o   = (passing | draining) & ~owner & s_ack_i;
  assign m1_ack_o   = (passing | draining) &  owner & s_ack_i;
  assign m0_err_o   = (passing | draining) & ~owner & s_err_i;
  assign m1_err_o   = (passing | draining) &  owner & s_err_i;

  assign accept      = s_stb_o & ~s_stall_i;
  assign done        = s_ack_i | s_err_i;
  // dropping cyc aborts the tenure; anything still outstanding is forgotten
  assign release_bus = (passing | draining) & ~own_cyc;
  assign ctr_clr     = ~(passing | draining) | release_bus;
  assign drain_done  = zero | ((outst == CW'(1)) & done);
  // preempt on the strobe that brings the starvation count to its limit
  assign starve_hit  = accept & other_cyc & (starve == SW'(STARVE_LIMIT - 1));
  // on a tie, the master that did not hold the bus last wins
  assign pick        = (m0_cyc_i && m1_cyc_i) ? ~last_owner : m1_cyc_i;

  mr_wb_txn_ctr #(
    .MAX_OUTST(MAX_OUTST)
  ) u_txn_ctr (
    .clk  (clk),
    .rst  (rst),
    .clr  (ctr_clr),
    .inc  (accept),
    .dec  (done),
    .count(outst),
    .full (full),
    .zero (zero)
  );

  // ownership state machine: grant, pass-through, drain on starvation, gap
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b0;
      starve     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (m0_cyc_i || m1_cyc_i) begin
            owner      <= pick;
            last_owner <= pick;
            starve     <= '0;
            state      <= pick ? OWN1 : OWN0;
          end
        end
        OWN0, OWN1: begin
          if (!own_cyc) begin
            state <= IDLE;
          end else begin
            if (accept && other_cyc) starve <= starve + SW'(1);
            if (starve_hit) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!own_cyc) state <= IDLE;
          else if (drain_done) state <= GAP;
        end
        GAP: begin
          if (other_cyc) begin
            owner      <= ~owner;
            last_owner <= ~owner;
            starve     <= '0;
            state      <= owner ? OWN0 : OWN1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mr_wb_arb.sv
// Self-checking bench for mr_wb_arb: directed scenarios plus a randomized run,
// all compared cycle by cycle against a transaction-level reference model.
module tb_mr_wb_arb;
  import mr_wb_pkg::*;

  localparam int AW   = WB_AW;
  localparam int DW   = WB_DW;
  localparam int SLW  = WB_SELW;
  localparam int MAXO = 4;
  localparam int LIM  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]     cyc, stb, we;
  logic [AW-1:0]  adr [2];
  logic [DW-1:0]  dat [2];
  logic [SLW-1:0] sel [2];
  logic           s_ack, s_err, s_stall;
  wire  [1:0]     ack_o, err_o, stall_o;
  wire            s_cyc, s_stb, s_we;
  wire  [AW-1:0]  s_adr;
  wire  [DW-1:0]  s_dat;
  wire  [SLW-1:0] s_sel;

  mr_wb_arb #(.MAX_OUTST(MAXO), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]),
    .m0_adr_i(adr[0]), .m0_dat_i(dat[0]), .m0_sel_i(sel[0]),
    .m0_ack_o(ack_o[0]), .m0_err_o(err_o[0]), .m0_stall_o(stall_o[0]),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]),
    .m1_adr_i(adr[1]), .m1_dat_i(dat[1]), .m1_sel_i(sel[1]),
    .m1_ack_o(ack_o[1]), .m1_err_o(err_o[1]), .m1_stall_o(stall_o[1]),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
    .s_adr_o(s_adr), .s_dat_o(s_dat), .s_sel_o(s_sel),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_stall_i(s_stall)
  );

  int n_chk = 0;
  int n_err = 0;

  // reference model: who holds the bus and the bookkeeping around it
  int holder;      // -1: nobody
  bit preempt;     // holder is being drained
  bit in_gap;      // the one idle cycle before handover
  int gap_from;
  int outst;
  int starve;
  int prev;        // master granted most recently

  int   acc_obs [2];
  int   ack_obs [2];
  bit   auto_ack;
  logic pend;
  logic last_scyc;
  logic [1:0] last_ack;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    holder = -1; preempt = 0; in_gap = 0; outst = 0; starve = 0; prev = 0;
  endtask

  task automatic grant(input int m);
    holder = m; prev = m; starve = 0; preempt = 0; outst = 0;
  endtask

  // one clock: check outputs mid-cycle, advance the model, cross the edge
  task automatic step();
    logic o_cyc, o_stb, full;
    logic [1:0] e_stall, e_ack, e_err;
    int h, acc, dn;
    @(negedge clk);
    h = holder;
    full = (outst == MAXO);
    e_stall = 2'b11; e_ack = 2'b00; e_err = 2'b00; o_cyc = 1'b0; o_stb = 1'b0;
    if (h >= 0 && !preempt) begin
      o_cyc = cyc[h];
      o_stb = stb[h] & ~full;
      e_stall[h] = s_stall | full;
      e_ack[h] = s_ack;
      e_err[h] = s_err;
    end else if (h >= 0) begin
      o_cyc = 1'b1;
      e_ack[h] = s_ack;
      e_err[h] = s_err;
    end
    check("s_cyc", 64'(s_cyc), 64'(o_cyc));
    check("s_stb", 64'(s_stb), 64'(o_stb));
    check("stall", 64'(stall_o), 64'(e_stall));
    check("ack", 64'(ack_o), 64'(e_ack));
    check("err", 64'(err_o), 64'(e_err));
    if (h >= 0 && !preempt) begin
      check("s_adr", 64'(s_adr), 64'(adr[h]));
      check("s_dat", 64'(s_dat), 64'(dat[h]));
      check("s_we", 64'(s_we), 64'(we[h]));
      check("s_sel", 64'(s_sel), 64'(sel[h]));
    end
    for (int m = 0; m < 2; m++) begin
      if (stb[m] && !stall_o[m]) acc_obs[m]++;
      if (ack_o[m]) ack_obs[m]++;
    end
    last_scyc = s_cyc;
    last_ack  = ack_o;
    pend      = s_stb & ~s_stall;

    acc = (o_stb && !s_stall) ? 1 : 0;
    dn  = ((s_ack || s_err) && outst > 0) ? 1 : 0;
    if (rst) begin
      model_reset();
    end else if (in_gap) begin
      in_gap = 0;
      if (cyc[1-gap_from]) grant(1 - gap_from);
    end else if (h < 0) begin
      if (cyc[0] && cyc[1]) grant(1 - prev);
      else if (cyc[0]) grant(0);
      else if (cyc[1]) grant(1);
    end else if (!cyc[h]) begin
      holder = -1; preempt = 0; outst = 0;
    end else begin
      outst = outst + acc - dn;
      if (!preempt) begin
        if (acc != 0 && cyc[1-h]) begin
          starve++;
          if (starve == LIM) preempt = 1;
        end
      end else if (outst == 0) begin
        preempt = 0; in_gap = 1; gap_from = h; holder = -1;
      end
    end
    @(posedge clk);
    #1;
    if (auto_ack) s_ack = pend;
  endtask

  task automatic quiet();
    rst = 1'b0; cyc = '0; stb = '0; we = '0;
    s_ack = 1'b0; s_err = 1'b0; s_stall = 1'b0; auto_ack = 1'b0;
    for (int m = 0; m < 2; m++) begin
      adr[m] = '0; dat[m] = '0; sel[m] = '0;
    end
  endtask

  task automatic do_reset();
    quiet();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int m = 0; m < 2; m++) begin
      acc_obs[m] = 0; ack_obs[m] = 0;
    end
  endtask

  initial begin
    quiet();
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // reset state, grant latency and address pass-through
    do_reset();
    check("rst_stall", 64'(stall_o), 64'(2'b11));
    check("rst_scyc", 64'(s_cyc), 64'(1'b0));
    step();
    cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = AW'(32'h100);
    step();
    check("grant_scyc", 64'(s_cyc), 64'(1'b1));
    check("grant_adr", 64'(s_adr), 64'(32'h100));
    s_stall = 1'b1; #1;
    check("stall_follow_hi", 64'(stall_o[0]), 64'(1'b1));
    s_stall = 1'b0; #1;
    check("stall_follow_lo", 64'(stall_o[0]), 64'(1'b0));
    repeat (3) step();

    // tie after reset goes to m1, next tie goes to m0
    do_reset();
    cyc = 2'b11;
    step();
    check("tie_first_m1", 64'(stall_o), 64'(2'b01));
    cyc = 2'b00;
    step();
    step();
    cyc = 2'b11;
    step();
    check("tie_second_m0", 64'(stall_o), 64'(2'b10));
    step();

    // outstanding limit with a slave that never acks
    do_reset();
    cyc[0] = 1'b1; stb[0] = 1'b1;
    step();
    repeat (8) step();
    check("full_accepts", 64'(acc_obs[0]), 64'(4));
    check("full_stb", 64'(s_stb), 64'(1'b0));
    check("full_stall", 64'(stall_o[0]), 64'(1'b1));
    s_ack = 1'b1;
    step();
    s_ack = 1'b0;
    repeat (4) step();
    check("full_one_more", 64'(acc_obs[0]), 64'(5));

    // starvation preemption with a one-cycle-ack slave
    do_reset();
    auto_ack = 1'b1;
    cyc[0] = 1'b1; stb[0] = 1'b1;
    step();
    cyc[1] = 1'b1; stb[1] = 1'b1;
    repeat (18) step();
    check("starve_m0_acc", 64'(acc_obs[0]), 64'(8));
    check("starve_m0_acks", 64'(ack_obs[0]), 64'(8));
    check("starve_m1_acc", 64'(acc_obs[1]), 64'(8));

    // accept and ack together at outst=3, then a stray ack with no owner
    do_reset();
    cyc[0] = 1'b1; stb[0] = 1'b1;
    step();
    repeat (3) step();
    s_ack = 1'b1;
    step();
    s_ack = 1'b0;
    repeat (4) step();
    check("same_cycle_acc", 64'(acc_obs[0]), 64'(5));
    cyc[0] = 1'b0; stb[0] = 1'b0;
    step();
    s_ack = 1'b1;
    step();
    check("stray_idle_ack", 64'(last_ack), 64'(2'b00));
    s_ack = 1'b0;

    // reset in the middle of an m1 tenure
    do_reset();
    cyc[1] = 1'b1; stb[1] = 1'b1;
    step();
    repeat (2) step();
    stb[1] = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; s_ack = 1'b1;
    step();
    check("rst_mid_scyc", 64'(last_scyc), 64'(1'b0));
    check("rst_mid_ack", 64'(last_ack), 64'(2'b00));
    quiet();
    step();

    // randomized traffic with sticky requests so preemption gets exercised
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(149) == 0);
      for (int m = 0; m < 2; m++) begin
        if ($urandom_range(19) == 0) cyc[m] = ~cyc[m];
        stb[m] = ($urandom_range(9) < 7);
        we[m]  = 1'($urandom);
        adr[m] = AW'($urandom);
        dat[m] = DW'($urandom);
        sel[m] = SLW'($urandom);
      end
      s_stall = ($urandom_range(3) == 0);
      s_ack   = ($urandom_range(9) < 4);
      s_err   = ($urandom_range(11) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
